// File: rtl/ula_pkg.sv
// Shared definitions for the ULA datapath: multiplier state encoding and
// the operand widths used by the default multiplier instance.
package ula_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ULA_MUL_WA = 5;
  localparam int ULA_MUL_WB = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/somador_n.sv
// N-bit ripple-carry adder chained from full_adder cells.
module somador_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fa
      full_adder u_fa (
        .a   (a[gi]),
        .b   (b[gi]),
        .cin (carry[gi]),
        .s   (sum[gi]),
        .cout(carry[gi+1])
      );
    end
  endgenerate

  assign cout = carry[N];

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential shift-add multiplier, full WA+WB product, unsigned or two's
// complement operands, start/busy/done handshake.
module multiplicador_seq
  import ula_pkg::*;
#(
  parameter int WA = ULA_MUL_WA,
  parameter int WB = ULA_MUL_WB
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [WA-1:0]   a,
  input  logic [WB-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [WA+WB-1:0] s
);

  localparam int CW = $clog2(WB);
  localparam int PW = WA + WB;

  state_e          state_q, state_d;
  logic [WA-1:0]   mcand_q, mcand_d;
  logic [WB-1:0]   mplr_q, mplr_d;
  logic [WA-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            done_q, done_d;
  logic [PW-1:0]   s_q, s_d;

  logic [WA-1:0]   neg_a;
  logic [WB-1:0]   neg_b;
  logic [PW-1:0]   prod, neg_prod;
  logic [WA-1:0]   add_b, add_sum;
  logic            add_cout;
  logic            neg_a_cout_unused, neg_b_cout_unused, neg_p_cout_unused;

  assign prod  = {acc_q, mplr_q};
  assign add_b = mplr_q[0] ? mcand_q : '0;

  // Two's-complement negation as ~x + 1 through the same ripple adder cells.
  somador_n #(.N(WA)) u_neg_a (
    .a(~a), .b('0), .cin(1'b1), .sum(neg_a), .cout(neg_a_cout_unused)
  );

  somador_n #(.N(WB)) u_neg_b (
    .a(~b), .b('0), .cin(1'b1), .sum(neg_b), .cout(neg_b_cout_unused)
  );

  somador_n #(.N(PW)) u_neg_p (
    .a(~prod), .b('0), .cin(1'b1), .sum(neg_prod), .cout(neg_p_cout_unused)
  );

  somador_n #(.N(WA)) u_acc (
    .a(acc_q), .b(add_b), .cin(1'b0), .sum(add_sum), .cout(add_cout)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    s_d     = s_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = (signed_mode & a[WA-1]) ? neg_a : a;
          mplr_d  = (signed_mode & b[WB-1]) ? neg_b : b;
          neg_d   = signed_mode & (a[WA-1] ^ b[WB-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Carry of the partial-product add becomes the new top bit of acc.
        acc_d  = {add_cout, add_sum[WA-1:1]};
        mplr_d = {add_sum[0], mplr_q[WB-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WB - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        s_d     = neg_q ? neg_prod : prod;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      s_q     <= s_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign s    = s_q;

endmodule
